// File: rtl/db_pkg.sv
// rtl/db_pkg.sv - shared command codes, controller states and constants for the debug controller
package db_pkg;

   typedef enum logic [3:0] {
      CMD_NOP    = 4'd0,
      CMD_PAUSE  = 4'd1,
      CMD_RESUME = 4'd2,
      CMD_RESET  = 4'd3,
      CMD_STATUS = 4'd4,
      CMD_MEM_RD = 4'd5,
      CMD_MEM_WR = 4'd6,
      CMD_REG_RD = 4'd7,
      CMD_REG_WR = 4'd8
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PAUSE_WAIT,
      ST_MEM_ACCESS,
      ST_MEM_WAIT,
      ST_REG_ACCESS,
      ST_DONE
   } ctrl_state_t;

   localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/debug_controller_if.sv
// rtl/debug_controller_if.sv - command/response link between the serial decoder and the debug controller
interface debug_controller_if;
   logic [3:0]  cmd;
   logic [31:0] addr;
   logic [31:0] d_in;
   logic        out_valid;
   logic        ctrlr_busy;
   logic [31:0] d_rd;
   logic        ctrlr_error;

   modport master (
      output cmd, addr, d_in, out_valid,
      input  ctrlr_busy, d_rd, ctrlr_error
   );

   modport slave (
      input  cmd, addr, d_in, out_valid,
      output ctrlr_busy, d_rd, ctrlr_error
   );
endinterface

// File: rtl/db_wait_timer.sv
// rtl/db_wait_timer.sv - loadable down-counter; done marks the last cycle of the loaded interval
module db_wait_timer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);
   logic [W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - W'(1);
   end

   // A load of N gives done in the N-th cycle after the load edge
   assign done = (count == W'(1));
endmodule

// File: rtl/debug_controller.sv
// rtl/debug_controller.sv - sequences serial debugger commands onto the MCU pause/reset, memory and register file ports
module debug_controller
   import db_pkg::*;
#(
   parameter int MEM_LATENCY   = 2,
   parameter int PAUSE_TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               reset,
   debug_controller_if.slave  ser,
   output logic               mcu_pause,
   input  logic               mcu_paused,
   output logic               mcu_reset,
   output logic [31:0]        mem_addr,
   output logic [31:0]        mem_din,
   output logic               mem_rd,
   output logic               mem_we,
   input  logic [31:0]        mem_dout,
   output logic [4:0]         rf_addr,
   output logic [31:0]        rf_din,
   output logic               rf_we,
   input  logic [31:0]        rf_dout
);
   ctrl_state_t state, state_n;
   logic [3:0]  cmd_q;
   logic [31:0] addr_q, din_q, d_rd_q;
   logic        busy_q, err_q;
   logic        accept, misaligned, mem_ok;
   logic        timer_load, timer_done;
   logic [31:0] timer_val;
   logic        set_pause, clr_pause, do_err, do_reset, do_status;
   logic        do_mem_rd, do_mem_wr, cap_mem, do_reg_rd, do_reg_wr;

   assign accept     = (state == ST_IDLE) && ser.out_valid;
   assign misaligned = |(addr_q[1:0] & WORD_ALIGN_MASK);
   assign mem_ok     = mcu_paused && !misaligned;

   db_wait_timer #(.W(32)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:
            if (ser.out_valid) begin
               case (ser.cmd)
                  CMD_PAUSE:              state_n = ST_PAUSE_WAIT;
                  CMD_MEM_RD, CMD_MEM_WR: state_n = ST_MEM_ACCESS;
                  default:                state_n = ST_REG_ACCESS;
               endcase
            end
         ST_PAUSE_WAIT: if (mcu_paused || timer_done) state_n = ST_DONE;
         ST_MEM_ACCESS: state_n = (mem_ok && cmd_q == CMD_MEM_RD) ? ST_MEM_WAIT : ST_DONE;
         ST_MEM_WAIT:   if (timer_done) state_n = ST_DONE;
         ST_REG_ACCESS: state_n = ST_DONE;
         default:       state_n = ST_IDLE;
      endcase
   end

   // ST_REG_ACCESS also executes the control-only commands and rejects illegal codes
   always_comb begin
      timer_load = 1'b0;
      timer_val  = '0;
      set_pause  = 1'b0;
      clr_pause  = 1'b0;
      do_err     = 1'b0;
      do_reset   = 1'b0;
      do_status  = 1'b0;
      do_mem_rd  = 1'b0;
      do_mem_wr  = 1'b0;
      cap_mem    = 1'b0;
      do_reg_rd  = 1'b0;
      do_reg_wr  = 1'b0;
      case (state)
         ST_IDLE:
            if (accept && ser.cmd == CMD_PAUSE) begin
               set_pause  = 1'b1;
               timer_load = 1'b1;
               timer_val  = 32'(PAUSE_TIMEOUT);
            end
         ST_PAUSE_WAIT:
            if (!mcu_paused && timer_done) begin
               clr_pause = 1'b1;
               do_err    = 1'b1;
            end
         ST_MEM_ACCESS:
            if (!mem_ok)
               do_err = 1'b1;
            else if (cmd_q == CMD_MEM_WR)
               do_mem_wr = 1'b1;
            else begin
               do_mem_rd  = 1'b1;
               timer_load = 1'b1;
               timer_val  = 32'(MEM_LATENCY);
            end
         ST_MEM_WAIT: cap_mem = timer_done;
         ST_REG_ACCESS:
            case (cmd_q)
               CMD_NOP:    begin end
               CMD_RESUME: clr_pause = 1'b1;
               CMD_RESET:  do_reset  = 1'b1;
               CMD_STATUS: do_status = 1'b1;
               CMD_REG_RD: if (mcu_paused) do_reg_rd = 1'b1; else do_err = 1'b1;
               CMD_REG_WR:
                  if (!mcu_paused)
                     do_err = 1'b1;
                  else if (addr_q[4:0] != 5'd0)
                     do_reg_wr = 1'b1;
               default:    do_err = 1'b1;
            endcase
         default: begin end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_q     <= '0;
         addr_q    <= '0;
         din_q     <= '0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         d_rd_q    <= '0;
         mcu_pause <= 1'b0;
         mcu_reset <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
         mem_rd    <= 1'b0;
         mem_we    <= 1'b0;
         rf_addr   <= '0;
         rf_din    <= '0;
         rf_we     <= 1'b0;
      end else begin
         busy_q    <= (state != ST_IDLE);
         err_q     <= do_err;
         mcu_reset <= do_reset;
         mem_rd    <= do_mem_rd;
         mem_we    <= do_mem_wr;
         rf_we     <= do_reg_wr;
         if (accept) begin
            cmd_q  <= ser.cmd;
            addr_q <= ser.addr;
            din_q  <= ser.d_in;
            // Register file reads are combinational, so the index must be out during ST_REG_ACCESS
            if (ser.cmd == CMD_REG_RD || ser.cmd == CMD_REG_WR)
               rf_addr <= ser.addr[4:0];
         end
         if (set_pause)      mcu_pause <= 1'b1;
         else if (clr_pause) mcu_pause <= 1'b0;
         if (do_mem_rd || do_mem_wr) mem_addr <= addr_q;
         if (do_mem_wr) mem_din <= din_q;
         if (do_reg_wr) rf_din  <= din_q;
         if (do_status)      d_rd_q <= {31'b0, mcu_paused};
         else if (do_reg_rd) d_rd_q <= rf_dout;
         else if (cap_mem)   d_rd_q <= mem_dout;
      end
   end

   assign ser.ctrlr_busy  = busy_q;
   assign ser.d_rd        = d_rd_q;
   assign ser.ctrlr_error = err_q;
endmodule

// File: tb/tb_debug_controller.sv
// tb/tb_debug_controller.sv - table-driven scoreboard bench for debug_controller
module tb_debug_controller;
   import db_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   debug_controller_if sif ();
   logic        mcu_pause, mcu_paused, mcu_reset;
   logic [31:0] mem_addr, mem_din, mem_dout;
   logic        mem_rd, mem_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_din, rf_dout;
   logic        rf_we;

   debug_controller #(.MEM_LATENCY(2), .PAUSE_TIMEOUT(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .ser        (sif),
      .mcu_pause  (mcu_pause),
      .mcu_paused (mcu_paused),
      .mcu_reset  (mcu_reset),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_rd     (mem_rd),
      .mem_we     (mem_we),
      .mem_dout   (mem_dout),
      .rf_addr    (rf_addr),
      .rf_din     (rf_din),
      .rf_we      (rf_we),
      .rf_dout    (rf_dout)
   );

   // Memory model: data is valid only in the cycle the controller must sample it
   logic [31:0] mem_m [logic [31:0]];
   logic [31:0] rf_m [32];
   assign rf_dout = rf_m[rf_addr];
   always @(posedge clk) begin
      if (mem_we) mem_m[mem_addr] = mem_din;
      if (mem_rd) mem_dout <= mem_m.exists(mem_addr) ? mem_m[mem_addr] : (32'hA5A50000 ^ mem_addr);
      else        mem_dout <= 32'h0BAD0BAD;
      if (rf_we) rf_m[rf_addr] <= rf_din;
   end

   typedef struct {
      logic [3:0]  cmd;
      logic [31:0] addr;
      logic [31:0] din;
      logic        paused;
      int          paused_at;
      int          lat;
      int          err;
      logic [31:0] drd;
      int          rd;
      int          we;
      int          rfwe;
      int          rst;
      logic        pause;
   } vec_t;

   vec_t tbl [25];
   vec_t exp_q [$];
   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic apply(input int idx, input vec_t v);
      vec_t e;
      int n_err, n_rd, n_we, n_rfwe, n_rst, fall;
      string p;
      @(negedge clk);
      mcu_paused    = v.paused;
      sif.cmd       = v.cmd;
      sif.addr      = v.addr;
      sif.d_in      = v.din;
      sif.out_valid = 1'b1;
      exp_q.push_back(v);
      @(posedge clk); #1;
      sif.out_valid = 1'b0;
      n_err = 0; n_rd = 0; n_we = 0; n_rfwe = 0; n_rst = 0; fall = -1;
      for (int i = 1; i <= 64 && fall < 0; i++) begin
         @(posedge clk); #1;
         if (i == v.paused_at) mcu_paused = 1'b1;
         n_err  += int'(sif.ctrlr_error);
         n_rd   += int'(mem_rd);
         n_we   += int'(mem_we);
         n_rfwe += int'(rf_we);
         n_rst  += int'(mcu_reset);
         if (!sif.ctrlr_busy) fall = i;
      end
      e = exp_q.pop_front();
      p = $sformatf("row%0d", idx);
      check({p, " busy_fall_edge"}, 32'(fall), 32'(e.lat));
      check({p, " error_pulses"}, 32'(n_err), 32'(e.err));
      check({p, " d_rd"}, sif.d_rd, e.drd);
      check({p, " mem_rd_pulses"}, 32'(n_rd), 32'(e.rd));
      check({p, " mem_we_pulses"}, 32'(n_we), 32'(e.we));
      check({p, " rf_we_pulses"}, 32'(n_rfwe), 32'(e.rfwe));
      check({p, " mcu_reset_pulses"}, 32'(n_rst), 32'(e.rst));
      check({p, " mcu_pause"}, 32'(mcu_pause), 32'(e.pause));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
      sif.cmd = 4'd0; sif.addr = 32'h0; sif.d_in = 32'h0; sif.out_valid = 1'b0;
      mcu_paused = 1'b0;

      //          cmd         addr          din           p   at  lat err drd          rd we rfwe rst pause
      tbl[0]  = '{CMD_NOP,    32'h0,        32'h0,        1'b0, -1, 3, 0, 32'h0,        0, 0, 0, 0, 1'b0};
      tbl[1]  = '{CMD_STATUS, 32'h0,        32'h0,        1'b0, -1, 3, 0, 32'h0,        0, 0, 0, 0, 1'b0};
      tbl[2]  = '{CMD_RESET,  32'h0,        32'h0,        1'b0, -1, 3, 0, 32'h0,        0, 0, 0, 1, 1'b0};
      tbl[3]  = '{4'd9,       32'h0,        32'h0,        1'b0, -1, 3, 1, 32'h0,        0, 0, 0, 0, 1'b0};
      tbl[4]  = '{4'd15,      32'h0,        32'h0,        1'b0, -1, 3, 1, 32'h0,        0, 0, 0, 0, 1'b0};
      tbl[5]  = '{CMD_REG_RD, 32'h3,        32'h0,        1'b0, -1, 3, 1, 32'h0,        0, 0, 0, 0, 1'b0};
      tbl[6]  = '{CMD_MEM_RD, 32'h100,      32'h0,        1'b0, -1, 3, 1, 32'h0,        0, 0, 0, 0, 1'b0};
      tbl[7]  = '{CMD_MEM_WR, 32'h100,      32'h11111111, 1'b0, -1, 3, 1, 32'h0,        0, 0, 0, 0, 1'b0};
      tbl[8]  = '{CMD_REG_WR, 32'h3,        32'h22222222, 1'b0, -1, 3, 1, 32'h0,        0, 0, 0, 0, 1'b0};
      tbl[9]  = '{CMD_PAUSE,  32'h0,        32'h0,        1'b0, -1, 18, 1, 32'h0,       0, 0, 0, 0, 1'b0};
      tbl[10] = '{CMD_PAUSE,  32'h0,        32'h0,        1'b0,  5, 8, 0, 32'h0,        0, 0, 0, 0, 1'b1};
      tbl[11] = '{CMD_STATUS, 32'h0,        32'h0,        1'b1, -1, 3, 0, 32'h1,        0, 0, 0, 0, 1'b1};
      tbl[12] = '{CMD_MEM_WR, 32'h100,      32'hDEADBEEF, 1'b1, -1, 3, 0, 32'h1,        0, 1, 0, 0, 1'b1};
      tbl[13] = '{CMD_MEM_RD, 32'h100,      32'h0,        1'b1, -1, 5, 0, 32'hDEADBEEF, 1, 0, 0, 0, 1'b1};
      tbl[14] = '{CMD_MEM_RD, 32'h102,      32'h0,        1'b1, -1, 3, 1, 32'hDEADBEEF, 0, 0, 0, 0, 1'b1};
      tbl[15] = '{CMD_MEM_WR, 32'h101,      32'h33333333, 1'b1, -1, 3, 1, 32'hDEADBEEF, 0, 0, 0, 0, 1'b1};
      tbl[16] = '{CMD_REG_WR, 32'h3,        32'h12345678, 1'b1, -1, 3, 0, 32'hDEADBEEF, 0, 0, 1, 0, 1'b1};
      tbl[17] = '{CMD_REG_RD, 32'h3,        32'h0,        1'b1, -1, 3, 0, 32'h12345678, 0, 0, 0, 0, 1'b1};
      tbl[18] = '{CMD_REG_WR, 32'h0,        32'hFFFFFFFF, 1'b1, -1, 3, 0, 32'h12345678, 0, 0, 0, 0, 1'b1};
      tbl[19] = '{CMD_REG_RD, 32'h0,        32'h0,        1'b1, -1, 3, 0, 32'h0,        0, 0, 0, 0, 1'b1};
      tbl[20] = '{CMD_MEM_RD, 32'h200,      32'h0,        1'b1, -1, 5, 0, 32'hA5A50200, 1, 0, 0, 0, 1'b1};
      tbl[21] = '{CMD_RESET,  32'h0,        32'h0,        1'b1, -1, 3, 0, 32'hA5A50200, 0, 0, 0, 1, 1'b1};
      tbl[22] = '{CMD_PAUSE,  32'h0,        32'h0,        1'b1, -1, 3, 0, 32'hA5A50200, 0, 0, 0, 0, 1'b1};
      tbl[23] = '{CMD_RESUME, 32'h0,        32'h0,        1'b1, -1, 3, 0, 32'hA5A50200, 0, 0, 0, 0, 1'b0};
      tbl[24] = '{CMD_NOP,    32'h0,        32'h0,        1'b1, -1, 3, 0, 32'hA5A50200, 0, 0, 0, 0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      check("reset ctrlr_busy", 32'(sif.ctrlr_busy), 32'h0);
      check("reset d_rd", sif.d_rd, 32'h0);
      check("reset ctrlr_error", 32'(sif.ctrlr_error), 32'h0);
      check("reset mcu_pause", 32'(mcu_pause), 32'h0);
      check("reset mcu_reset", 32'(mcu_reset), 32'h0);
      check("reset mem_rd", 32'(mem_rd), 32'h0);
      check("reset mem_we", 32'(mem_we), 32'h0);
      check("reset mem_addr", mem_addr, 32'h0);
      check("reset rf_we", 32'(rf_we), 32'h0);
      check("reset rf_addr", 32'(rf_addr), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 25; i++) apply(i, tbl[i]);

      // Reset while a read waits in MEM_WAIT: everything drops asynchronously
      v = '{CMD_PAUSE, 32'h0, 32'h0, 1'b1, -1, 3, 0, 32'hA5A50200, 0, 0, 0, 0, 1'b1};
      apply(25, v);
      @(negedge clk);
      sif.cmd = CMD_MEM_RD; sif.addr = 32'h100; sif.out_valid = 1'b1;
      @(posedge clk); #1;
      sif.out_valid = 1'b0;
      @(posedge clk); #1;
      check("memwait mem_rd before reset", 32'(mem_rd), 32'h1);
      check("memwait busy before reset", 32'(sif.ctrlr_busy), 32'h1);
      reset = 1'b1;
      #1;
      check("async reset ctrlr_busy", 32'(sif.ctrlr_busy), 32'h0);
      check("async reset mcu_pause", 32'(mcu_pause), 32'h0);
      check("async reset mem_rd", 32'(mem_rd), 32'h0);
      check("async reset mem_addr", mem_addr, 32'h0);
      check("async reset d_rd", sif.d_rd, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      v = '{CMD_STATUS, 32'h0, 32'h0, 1'b1, -1, 3, 0, 32'h1, 0, 0, 0, 0, 1'b0};
      apply(26, v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/debug_controller.md
# debug_controller

Sequences debugger commands decoded by the UART serial front end onto the RISC-V MCU. It pauses, resumes and resets the core, and performs word reads and writes to memory and the register file. It sits between the `serial` decoder (`cmd`, `addr`, `d_in`, `out_valid` in; `ctrlr_busy`, `d_rd` out) and the MCU debug ports. It accepts one command at a time and holds `ctrlr_busy` until that command has fully retired.

## Interface
- `MEM_LATENCY`, 2: cycles from the `mem_rd` pulse to valid `mem_dout`; must be ≥1.
- `PAUSE_TIMEOUT`, 1024: maximum cycles to wait for `mcu_paused` after a pause request.
- `clk` in 1: single system clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `cmd` in 4: command code from the serial decoder.
- `addr` in 32: memory byte address, or register index in `[4:0]`.
- `d_in` in 32: write data.
- `out_valid` in 1: one-cycle strobe; `cmd`/`addr`/`d_in` are valid.
- `ctrlr_busy` out 1: command in progress.
- `d_rd` out 32: read result, returned to serial.
- `ctrlr_error` out 1: one-cycle error pulse.
- `mcu_pause` out 1: level pause request to the core.
- `mcu_paused` in 1: core has drained and halted.
- `mcu_reset` out 1: one-cycle core reset pulse.
- `mem_addr` out 32, `mem_din` out 32, `mem_rd` out 1, `mem_we` out 1, `mem_dout` in 32: word memory port.
- `rf_addr` out 5, `rf_din` out 32, `rf_we` out 1, `rf_dout` in 32: register file port; reads are combinational.

## Operation
- Command codes: 0 NOP, 1 PAUSE, 2 RESUME, 3 RESET, 4 STATUS, 5 MEM_RD, 6 MEM_WR, 7 REG_RD, 8 REG_WR. Codes 9–15 are illegal.
- States: IDLE, PAUSE_WAIT, MEM_ACCESS, MEM_WAIT, REG_ACCESS, DONE.
- IDLE + `out_valid`: latch `cmd`, `addr` and `d_in`. When not in IDLE, `out_valid` is ignored with no error.
- NOP: go to DONE.
- PAUSE: set `mcu_pause`, then go to PAUSE_WAIT.
  - PAUSE_WAIT exits to DONE on `mcu_paused`.
  - If `PAUSE_TIMEOUT` cycles elapse first, clear `mcu_pause`, pulse `ctrlr_error`, and go to DONE.
  - PAUSE while already paused goes to DONE with no error.
- RESUME: clear `mcu_pause`, then go to DONE.
- RESET: pulse `mcu_reset` for one cycle, then go to DONE. `mcu_pause` is unchanged.
- STATUS: `d_rd` ← {31'b0, `mcu_paused`}, then go to DONE.
- MEM_RD/MEM_WR/REG_RD/REG_WR require `mcu_paused`=1. If it is 0, pulse `ctrlr_error`, perform no bus activity, and go to DONE.
- MEM_RD/MEM_WR with `addr[1:0]`≠0: pulse `ctrlr_error` with no access.
- MEM_WR: in MEM_ACCESS, drive `mem_we`=1, `mem_addr`, `mem_din` for one cycle, then go to DONE.
- MEM_RD: in MEM_ACCESS, drive `mem_rd`=1 for one cycle. MEM_WAIT counts `MEM_LATENCY`, then captures `mem_dout` into `d_rd`.
- REG_RD: in REG_ACCESS, `d_rd` ← `rf_dout` for `rf_addr`=`addr[4:0]`.
- REG_WR: `rf_we` pulse. When `addr[4:0]`=0, `rf_we` is suppressed; this is not an error.
- Illegal code: pulse `ctrlr_error`, then go to DONE.
- DONE: one cycle, then return to IDLE.
- `d_rd` holds its last value except on a read or STATUS.

## Timing
- Reset values: `ctrlr_busy`=0, `d_rd`=0, `ctrlr_error`=0, `mcu_pause`=0, `mcu_reset`=0, `mem_*`=0, `rf_*`=0, state=IDLE.
- Reset mid-command aborts immediately and releases the core (`mcu_pause`=0).
- Let `out_valid` be sampled at edge N. Then `ctrlr_busy`=1 from N+1 until the edge leaving DONE.
  - ctrl-only commands (NOP, PAUSE already set, RESUME, RESET, STATUS, REG_*, errors): `ctrlr_busy` falls at N+3.
- MEM_RD: `mem_rd` is high in cycle N+1. `mem_dout` is sampled at edge N+1+`MEM_LATENCY`. `d_rd` is valid and `ctrlr_busy` is low at N+3+`MEM_LATENCY`.
- MEM_WR: `mem_we` is high in cycle N+1; `ctrlr_busy` falls at N+3.
- `ctrlr_error` rises in the cycle after the error is detected and lasts one cycle.
- `mcu_reset` rises in cycle N+1 and lasts one cycle.
- PAUSE timeout fires on the `PAUSE_TIMEOUT`-th PAUSE_WAIT cycle. `mcu_paused` asserted in that same cycle wins: no error.

## Structure
- Package `db_pkg`:
  - `cmd_t` enum with the 4-bit codes above.
  - `ctrl_state_t` enum.
  - Constant `WORD_ALIGN_MASK`=2'b11.
- Sub-module `db_wait_timer`: loadable down-counter with a `done` flag. One instance, shared by MEM_WAIT (loaded with `MEM_LATENCY`) and PAUSE_WAIT (loaded with `PAUSE_TIMEOUT`).

## Test plan
- PAUSE with `mcu_paused` rising 5 cycles later → `mcu_pause`=1 holds; busy falls 2 cycles after `mcu_paused`; no error.
- PAUSE with `mcu_paused` tied 0, `PAUSE_TIMEOUT`=16 → `ctrlr_error` pulse after 16 cycles; `mcu_pause` returns to 0.
- Paused; MEM_WR addr=0x100, d_in=0xDEADBEEF; then MEM_RD addr=0x100 with a model memory at `MEM_LATENCY`=2 → one `mem_we` pulse; `d_rd`=0xDEADBEEF at N+5.
- MEM_RD addr=0x102 while paused → `ctrlr_error`; no `mem_rd`. REG_RD while not paused → `ctrlr_error`; `d_rd` unchanged.
- Paused; REG_WR addr=3, d_in=0x12345678, then REG_RD addr=3 → `d_rd`=0x12345678. REG_WR addr=0 → no `rf_we`.
- Assert `reset` in MEM_WAIT → all outputs return to reset values asynchronously; next STATUS returns `d_rd`=`mcu_paused`.
